jtframe_cpucen_wait: RTL

Parametrised clock-enable generator with wait-state gating for 6809-class two-phase CPUs (E/Q) and similar cores. It divides the input `cen` by `DIV`, suspends the CPU phase while any ROM channel is waiting for SDRAM data or any shared bus is busy, and optionally recovers cycles lost to ROM waits. It sits between the game clock-enable tree and the CPU wrapper, replacing single-channel fixed-divide-by-4 wait logic.

---
 rtl/jtframe_cpucen_pkg.sv | 18 +
 rtl/jtframe_cenwait_fsm.sv | 75 +++++++
 rtl/jtframe_cpucen_wait.sv | 67 ++++++
 3 files changed

// File: rtl/jtframe_cpucen_pkg.sv
// rtl/jtframe_cpucen_pkg.sv - shared state encoding and phase-distance helper for the wait-gated CPU enable
package jtframe_cpucen_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_ROM = 2'd1,
    ST_WAIT_BUS = 2'd2,
    ST_CATCHUP  = 2'd3
  } cen_state_e;

  // cen ticks from ph to the next pulse phase (0 or div/2)
  function automatic int unsigned pulse_dist(input int unsigned ph, input int unsigned div);
    int unsigned h;
    h = div >> 1;
    return (ph < h) ? (h - ph) : (div - ph);
  endfunction

endpackage

// File: rtl/jtframe_cenwait_fsm.sv
// rtl/jtframe_cenwait_fsm.sv - wait/catch-up state machine and saturating miss counter
module jtframe_cenwait_fsm
  import jtframe_cpucen_pkg::*;
#(
  parameter int DIV      = 4,
  parameter int RECOVERY = 1,
  parameter int MISSW    = 4,
  parameter int PHW      = $clog2(DIV)
) (
  input  logic             rstn,
  input  logic             clk,
  input  logic             cen,
  input  logic             rom_wait,
  input  logic             bus_wait,
  input  logic [PHW-1:0]   ph,
  output logic [1:0]       step,
  output logic             gate,
  output logic             stall,
  output logic [MISSW-1:0] misses
);

  cen_state_e       st, mode, st_nx;
  logic [MISSW-1:0] misses_nx;
  logic             far;

  assign far = pulse_dist(32'(ph), DIV) >= 2;

  // mode is the behaviour for this tick: a cleared wait resumes on the same tick
  always_comb begin
    if (bus_wait)
      mode = ST_WAIT_BUS;
    else if (rom_wait)
      mode = ST_WAIT_ROM;
    else if (st != ST_RUN && RECOVERY != 0 && misses != '0)
      mode = ST_CATCHUP;
    else
      mode = ST_RUN;

    gate      = (mode == ST_RUN) || (mode == ST_CATCHUP);
    step      = 2'd0;
    misses_nx = misses;
    st_nx     = mode;
    case (mode)
      ST_RUN: step = 2'd1;
      ST_WAIT_ROM: begin
        if (RECOVERY != 0 && misses != '1)
          misses_nx = misses + 1'b1;
      end
      ST_CATCHUP: begin
        if (far) begin
          step      = 2'd2;
          misses_nx = misses - 1'b1;
        end else begin
          step = 2'd1;
        end
        if (misses_nx == '0)
          st_nx = ST_RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st     <= ST_RUN;
      misses <= '0;
      stall  <= 1'b0;
    end else if (cen) begin
      st     <= st_nx;
      misses <= misses_nx;
      stall  <= (st_nx == ST_WAIT_ROM) || (st_nx == ST_WAIT_BUS);
    end
  end

endmodule

// File: rtl/jtframe_cpucen_wait.sv
// rtl/jtframe_cpucen_wait.sv - E/Q clock-enable divider with ROM/bus wait gating and cycle recovery
module jtframe_cpucen_wait
  import jtframe_cpucen_pkg::*;
#(
  parameter int DIV      = 4,
  parameter int DEVCNT   = 2,
  parameter int BUSCNT   = 1,
  parameter int RECOVERY = 1,
  parameter int MISSW    = 4
) (
  input  logic              rstn,
  input  logic              clk,
  input  logic              cen,
  input  logic [DEVCNT-1:0] rom_cs,
  input  logic [DEVCNT-1:0] rom_ok,
  input  logic [BUSCNT-1:0] dev_busy,
  output logic              cen_E,
  output logic              cen_Q,
  output logic              cpu_cen,
  output logic              stall,
  output logic [MISSW-1:0]  misses
);

  localparam int             PHW   = $clog2(DIV);
  localparam logic [PHW:0]   DIV_W = (PHW+1)'(DIV);
  localparam logic [PHW-1:0] HALF  = PHW'(DIV / 2);

  logic [PHW-1:0] ph;
  logic [PHW:0]   ph_sum;
  logic [1:0]     step;
  logic           gate, rom_wait, bus_wait;

  assign rom_wait = |(rom_cs & ~rom_ok);
  assign bus_wait = |dev_busy;
  assign ph_sum   = {1'b0, ph} + {{(PHW-1){1'b0}}, step};

  jtframe_cenwait_fsm #(
    .DIV      (DIV),
    .RECOVERY (RECOVERY),
    .MISSW    (MISSW),
    .PHW      (PHW)
  ) u_fsm (
    .rstn     (rstn),
    .clk      (clk),
    .cen      (cen),
    .rom_wait (rom_wait),
    .bus_wait (bus_wait),
    .ph       (ph),
    .step     (step),
    .gate     (gate),
    .stall    (stall),
    .misses   (misses)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      ph <= '0;
    else if (cen)
      ph <= (ph_sum >= DIV_W) ? PHW'(ph_sum - DIV_W) : ph_sum[PHW-1:0];
  end

  // Pulses decode the pre-update phase so catch-up jumps never hide a pulse
  assign cen_E   = rstn & cen & gate & (ph == '0);
  assign cen_Q   = rstn & cen & gate & (ph == HALF);
  assign cpu_cen = cen_Q;

endmodule
